// File: rtl/prince_share_io.sv
// Share/unshare wrapper around the 5-share PRINCE core: masks the request with one
// fresh randomness word, runs the core with a timeout guard and recombines its result.
module prince_share_io #(
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned CW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_enc,
    input  logic [63:0]  in_data,
    input  logic [127:0] in_key,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    input  logic [255:0] rnd,
    output logic         core_en,
    output logic         core_enc,
    output logic [63:0]  core_p0,
    output logic [63:0]  core_p1,
    output logic [63:0]  core_p2,
    output logic [63:0]  core_p3,
    output logic [63:0]  core_p4,
    output logic [127:0] core_k,
    input  logic [63:0]  core_c0,
    input  logic [63:0]  core_c1,
    input  logic [63:0]  core_c2,
    input  logic [63:0]  core_c3,
    input  logic [63:0]  core_c4,
    input  logic         core_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         err
);

    typedef enum logic [1:0] {IDLE, WAIT_RND, RUN, OUT} state_e;

    state_e         state_q;
    logic [63:0]    data_q;
    logic [127:0]   key_q;
    logic           enc_q;
    logic [63:0]    p0_q, p1_q, p2_q, p3_q, p4_q;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    out_data_q;
    logic           err_q;

    logic [63:0]    share_src;
    logic [63:0]    p0_d;
    logic           timeout_hit;

    // Masking straight from in_data lets a request with randomness ready skip WAIT_RND.
    assign share_src   = (state_q == IDLE) ? in_data : data_q;
    assign p0_d        = share_src ^ rnd[63:0] ^ rnd[127:64] ^ rnd[191:128] ^ rnd[255:192];
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    assign in_ready  = (state_q == IDLE);
    assign rnd_ready = ((state_q == IDLE) && in_valid) || (state_q == WAIT_RND);
    assign core_en   = (state_q == RUN);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign core_enc  = enc_q;
    assign core_k    = key_q;
    assign core_p0   = p0_q;
    assign core_p1   = p1_q;
    assign core_p2   = p2_q;
    assign core_p3   = p3_q;
    assign core_p4   = p4_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            key_q      <= '0;
            enc_q      <= 1'b0;
            p0_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            p4_q       <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        key_q <= in_key;
                        enc_q <= in_enc;
                        if (rnd_valid) begin
                            p0_q    <= p0_d;
                            p1_q    <= rnd[63:0];
                            p2_q    <= rnd[127:64];
                            p3_q    <= rnd[191:128];
                            p4_q    <= rnd[255:192];
                            data_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            data_q  <= in_data;
                            state_q <= WAIT_RND;
                        end
                    end
                end
                WAIT_RND: begin
                    // The unmasked copy is wiped as soon as it has been folded into p0.
                    if (rnd_valid) begin
                        p0_q    <= p0_d;
                        p1_q    <= rnd[63:0];
                        p2_q    <= rnd[127:64];
                        p3_q    <= rnd[191:128];
                        p4_q    <= rnd[255:192];
                        data_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (core_done) begin
                        out_data_q <= core_c0 ^ core_c1 ^ core_c2 ^ core_c3 ^ core_c4;
                        state_q    <= OUT;
                    end else if (timeout_hit) begin
                        err_q      <= 1'b1;
                        out_data_q <= '0;
                        state_q    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/prince_share_io.md
Name: prince_share_io

Overview:
- Front/back-end stage for the 5-share PRINCE encryption core.
- Accepts an unmasked plaintext, key and direction over a valid/ready handshake, and splits the plaintext into 5 Boolean shares using fresh randomness from the PRNG.
- Drives the core's p0..p4/k/enc/en inputs, waits for done, captures and recombines c0..c4, then returns the unmasked result over a second valid/ready handshake.
- Sits directly upstream and downstream of the masked core; the core's own ports are driven only by this block.

Parameters:
- TIMEOUT, 31, maximum cycles spent in RUN before aborting with err; must be greater than the core latency.
- CW, 5, width of the RUN cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_enc  in  1  1 = encrypt, 0 = decrypt.
- in_data  in  64  unmasked plaintext/ciphertext.
- in_key  in  128  key.
- rnd_valid  in  1  fresh randomness present.
- rnd_ready  out  1  randomness consumed when rnd_valid && rnd_ready.
- rnd  in  256  four 64-bit masks r0..r3 (r0 = [63:0]).
- core_en, core_enc  out  1 each  to core.
- core_p0..core_p4  out  64 each  plaintext shares to core.
- core_k  out  128  key to core.
- core_c0..core_c4  in  64 each  ciphertext shares from core.
- core_done  in  1  core result valid.
- out_valid  out  1  result present.
- out_ready  in  1  result taken when out_valid && out_ready.
- out_data  out  64  recombined result.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all data registers 0; in_ready=1, rnd_ready=0, core_en=0, out_valid=0, err=0.
- FSM states: IDLE, WAIT_RND, RUN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: register in_data, in_key, in_enc.
  - If rnd_valid is high in the same cycle, register shares directly and go to RUN; otherwise go to WAIT_RND.
- Share formation (registered):
  - p1..p4 = r0..r3.
  - p0 = data ^ r0 ^ r1 ^ r2 ^ r3.
  - rnd_ready=1 only in IDLE-with-in_valid and in WAIT_RND, so one rnd word is consumed per request, never reused.
  - Shares, key and enc are held stable for the whole of RUN.
- WAIT_RND: in_ready=0, rnd_ready=1. Stay until rnd_valid, then register shares and go to RUN.
- RUN:
  - core_en=1 for every RUN cycle; counter starts at 0 on entry and increments each cycle.
  - On core_done=1: out_data <= c0^c1^c2^c3^c4 (registered), core_en drops next cycle, go to OUT.
  - If the counter reaches TIMEOUT without done: err <= 1 (sticky until reset), out_data <= 0, go to OUT.
  - done takes priority if it coincides with the timeout cycle; err stays 0.
- OUT:
  - out_valid=1; out_data stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
- core_en is 0 in every state except RUN.
- core_p*, core_k and core_enc are driven from registers, never combinationally from in_*.
- Latency with rnd_valid present and the core asserting done N cycles after core_en rises:
  - accept at cycle 0, RUN from cycle 1, out_valid at cycle N+2.
  - Each cycle without rnd_valid adds one cycle.
- Back-to-back: in_ready returns the cycle after the out handshake; no overlap of requests.
- Shares are never combined except in the final XOR tree feeding out_data; no intermediate unmasked value of p0 is stored.
- in_valid in states other than IDLE is ignored (in_ready=0).
- Reset mid-RUN: core_en drops immediately (asynchronously); the in-flight request is lost, no out_valid.

Test Plan:
- Encrypt, in_data=0, in_key=0, rnd_valid always high with random rnd -> out_data=818665aa0d02dfda, err=0; core_p0^...^core_p4 = 0 throughout RUN.
- Encrypt, in_data=ffffffffffffffff, in_key=0 -> out_data=604ae6ca03c20ada. Repeat with three different rnd values: same result, core_p1..p4 differ each time.
- Decrypt (in_enc=0) of 818665aa0d02dfda with key=0 -> out_data=0. rnd_valid held low 5 cycles after acceptance -> WAIT_RND for 5 cycles, out_valid delayed by exactly 5 cycles.
- out_ready held low 10 cycles -> out_valid and out_data stable; in_ready=0 throughout; one rnd word consumed per request across 4 back-to-back requests.
- Core model never asserts done -> after TIMEOUT cycles err=1, out_data=0, out_valid=1; err stays 1 on the next good request until rst.
- Assert rst low mid-RUN -> core_en=0 and in_ready=1 asynchronously; no out_valid after release; the next request completes correctly.
